// File: rtl/adc_parallel_responder.sv
// Parallel-bus ADC emulator: conversion timing, EOC pulse, read-back, config writes,
// shutdown/wake sequencing. Stands in for the physical converter on the controller's bus.
module adc_parallel_responder #(
  parameter int DATA_W      = 16,
  parameter int CONV_CYCLES = 200,
  parameter int EOC_CYCLES  = 4,
  parameter int WAKE_CYCLES = 50,
  parameter int RAMP_STEP   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SHDN,
  input  logic              CONVST,
  input  logic              CS,
  input  logic              RD,
  input  logic              WR,
  input  logic [DATA_W-1:0] db_in,
  input  logic [DATA_W-1:0] sample_in,
  output logic              EOC,
  output logic [DATA_W-1:0] db_out,
  output logic              db_oe,
  output logic              busy,
  output logic              overrun
);

  localparam int MAX_A   = (CONV_CYCLES > EOC_CYCLES) ? CONV_CYCLES : EOC_CYCLES;
  localparam int MAX_CYC = (MAX_A > WAKE_CYCLES) ? MAX_A : WAKE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONVERT,
    S_EOC_PULSE,
    S_SHUTDOWN,
    S_WAKE
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  hold;
  logic [DATA_W-1:0]  result;
  logic [DATA_W-1:0]  ramp;
  logic [1:0]         cfg;
  logic               prev_convst;
  logic               prev_wr;
  logic               convst_rise;
  logic               wr_fall;
  logic               rd_req;
  logic [DATA_W-1:0]  src;
  logic               unused_db_hi;

  assign convst_rise  = CONVST & ~prev_convst;
  assign wr_fall      = prev_wr & ~WR;
  assign rd_req       = ~CS & ~RD;
  assign src          = cfg[0] ? ramp : sample_in;
  assign unused_db_hi = ^db_in[DATA_W-1:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      hold        <= '0;
      result      <= '0;
      ramp        <= '0;
      cfg         <= '0;
      prev_convst <= 1'b0;
      prev_wr     <= 1'b1;
      EOC         <= 1'b1;
      db_out      <= '0;
      db_oe       <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      prev_convst <= CONVST;
      prev_wr     <= WR;
      if (SHDN) begin
        state <= S_SHUTDOWN;
        EOC   <= 1'b1;
        db_oe <= 1'b0;
        busy  <= 1'b0;
      end else begin
        if (state != S_SHUTDOWN) begin
          db_oe <= rd_req;
          if (rd_req) db_out <= result;
          if (wr_fall && !CS) begin
            cfg     <= db_in[1:0];
            overrun <= 1'b0;
          end
        end
        // Overrun set below takes precedence over a same-cycle config-write clear.
        case (state)
          S_IDLE: begin
            if (convst_rise) begin
              hold  <= src;
              cnt   <= CNT_W'(CONV_CYCLES - 1);
              busy  <= 1'b1;
              state <= S_CONVERT;
            end
          end
          S_CONVERT: begin
            if (convst_rise) overrun <= 1'b1;
            if (cnt == '0) begin
              result <= cfg[1] ? ~hold : hold;
              ramp   <= ramp + DATA_W'(RAMP_STEP);
              EOC    <= 1'b0;
              busy   <= 1'b0;
              cnt    <= CNT_W'(EOC_CYCLES - 1);
              state  <= S_EOC_PULSE;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          S_EOC_PULSE: begin
            if (cnt == '0) begin
              EOC <= 1'b1;
              if (convst_rise) begin
                hold  <= src;
                cnt   <= CNT_W'(CONV_CYCLES - 1);
                busy  <= 1'b1;
                state <= S_CONVERT;
              end else begin
                state <= S_IDLE;
              end
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          S_SHUTDOWN: begin
            cnt   <= CNT_W'(WAKE_CYCLES - 1);
            busy  <= 1'b1;
            state <= S_WAKE;
          end
          S_WAKE: begin
            if (convst_rise) overrun <= 1'b1;
            if (cnt == '0) begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
